// File: rtl/mips_defs_pkg.sv
// -----------------------------------------------------------------------------
// mips_defs : shared definitions for the five-stage MIPS pipeline front end.
//
// Contents
//   - npc_sel_e      : next-PC source encodings driven by the ID controller
//   - PC_RESET_DEFAULT / IM_WORDS_DEFAULT : default fetch-unit configuration
//   - EXC_ADEL / EXC_NONE : exception codes carried down the pipe
//   - word/half byte sizes and the all-zero bubble instruction
//   - ifid_t         : IF/ID pipeline register contents
//   - sign_ext16()   : 16-to-32 bit sign extension for branch offsets
// -----------------------------------------------------------------------------
package mips_defs;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam int          IM_WORDS_DEFAULT = 4096;

    typedef enum logic [1:0] {
        NPC_PC4 = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_sel_e;

    localparam logic [4:0]  EXC_NONE   = 5'd0;
    localparam logic [4:0]  EXC_ADEL   = 5'd4;

    localparam logic [31:0] WORD_BYTES = 32'd4;
    localparam logic [31:0] HALF_BYTES = 32'd2;
    localparam logic [31:0] INSTR_NOP  = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } ifid_t;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/npc_calc.sv
// -----------------------------------------------------------------------------
// npc_calc : combinational next-PC selection for the fetch stage.
//
// Ports
//   pc_i         in  32  current fetch PC (source of the sequential PC+4)
//   id_pc_i      in  32  PC of the instruction held in ID
//   id_index_i   in  26  index/immediate field of the ID instruction
//   id_valid_i   in   1  ID holds a real instruction; bubbles force PC+4
//   npc_sel_i    in   2  next-PC source (see mips_defs::npc_sel_e)
//   br_taken_i   in   1  branch condition, only meaningful for NPC_BR
//   jr_target_i  in  32  register target for jr/jalr, used unmodified
//   npc_o        out 32  selected next PC
// -----------------------------------------------------------------------------
module npc_calc
    import mips_defs::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] id_pc_i,
    input  logic [25:0] id_index_i,
    input  logic        id_valid_i,
    input  logic [1:0]  npc_sel_i,
    input  logic        br_taken_i,
    input  logic [31:0] jr_target_i,
    output logic [31:0] npc_o
);

    logic [31:0] seq_pc;
    logic [31:0] id_pc4;
    logic [31:0] br_target;
    logic [31:0] j_target;

    // Plain 32-bit adders: 0xFFFF_FFFC + 4 wraps to 0 by design.
    assign seq_pc    = pc_i + WORD_BYTES;
    assign id_pc4    = id_pc_i + WORD_BYTES;
    // Branch and jump targets are relative to the delay slot (id_pc + 4).
    assign br_target = id_pc4 + (sign_ext16(id_index_i[15:0]) << 2);
    assign j_target  = {id_pc4[31:28], id_index_i, 2'b00};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        npc_o = seq_pc;
        if (id_valid_i) begin
            case (npc_sel_e'(npc_sel_i))
                NPC_BR:  if (br_taken_i) npc_o = br_target;
                NPC_J:   npc_o = j_target;
                NPC_JR:  npc_o = jr_target_i;
                default: npc_o = seq_pc;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit : instruction-fetch stage of the five-stage MIPS pipeline.
//
// Holds the PC, drives the word address into instruction memory, captures the
// returned word into the IF/ID register and advances the PC from the
// instruction in ID (branches have a delay slot; nothing is squashed).
//
// Parameters
//   PC_RESET  PC after reset and base address of instruction memory
//   IM_WORDS  instruction memory depth in words
//
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-high reset
//   stall      in   1   freezes PC and IF/ID
//   flush      in   1   loads a bubble into IF/ID
//   npc_sel    in   2   next-PC source from the ID controller
//   br_taken   in   1   branch condition for npc_sel = branch
//   jr_target  in  32   forwarded rs value for jr/jalr
//   im_addr    out AW   word address into instruction memory (modulo IM_WORDS)
//   im_data    in  32   instruction word, combinational on im_addr
//   if_pc      out 32   current fetch PC
//   id_instr   out 32   instruction in ID
//   id_pc      out 32   PC of instruction in ID
//   id_pc8     out 32   id_pc + 8, link value for jal/jalr
//   id_valid   out  1   ID holds a real instruction
//   id_exc     out  5   exception code in ID (only with FETCH_ADDR_EXC_EN)
//
// Build option
//   FETCH_ADDR_EXC_EN : flags misaligned or out-of-range fetch PCs as AdEL.
// -----------------------------------------------------------------------------
module fetch_unit
    import mips_defs::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          IM_WORDS = IM_WORDS_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        flush,
    input  logic [1:0]                  npc_sel,
    input  logic                        br_taken,
    input  logic [31:0]                 jr_target,
    output logic [$clog2(IM_WORDS)-1:0] im_addr,
    input  logic [31:0]                 im_data,
    output logic [31:0]                 if_pc,
    output logic [31:0]                 id_instr,
    output logic [31:0]                 id_pc,
    output logic [31:0]                 id_pc8,
    output logic                        id_valid
`ifdef FETCH_ADDR_EXC_EN
    ,
    output logic [4:0]                  id_exc
`endif
);

    localparam int AW = $clog2(IM_WORDS);

    logic [31:0] pc_q, pc_d;
    ifid_t       ifid_q, ifid_d;
    logic [31:0] npc;

`ifdef FETCH_ADDR_EXC_EN
    localparam logic [32:0] IM_BYTES = 33'(IM_WORDS) << 2;

    logic [4:0]  exc_q, exc_d;
    logic [31:0] pc_off;
    logic        fetch_fault;

    // A PC below PC_RESET wraps to a huge offset, so one unsigned compare
    // covers both ends of the window.
    assign pc_off      = pc_q - PC_RESET;
    assign fetch_fault = (pc_q[1:0] != 2'b00) || ({1'b0, pc_off} >= IM_BYTES);
    assign id_exc      = exc_q;
`endif

    npc_calc u_npc_calc (
        .pc_i        (pc_q),
        .id_pc_i     (ifid_q.pc),
        .id_index_i  (ifid_q.instr[25:0]),
        .id_valid_i  (ifid_q.valid),
        .npc_sel_i   (npc_sel),
        .br_taken_i  (br_taken),
        .jr_target_i (jr_target),
        .npc_o       (npc)
    );

    always_comb begin
        pc_d   = pc_q;
        ifid_d = ifid_q;
`ifdef FETCH_ADDR_EXC_EN
        exc_d  = exc_q;
`endif
        if (!stall) begin
            pc_d = npc;
        end

        // flush wins over stall for IF/ID; a bubble keeps the old id_pc.
        if (flush) begin
            ifid_d.instr = INSTR_NOP;
            ifid_d.valid = 1'b0;
`ifdef FETCH_ADDR_EXC_EN
            exc_d        = EXC_NONE;
`endif
        end else if (!stall) begin
            ifid_d.instr = im_data;
            ifid_d.pc    = pc_q;
            ifid_d.valid = 1'b1;
`ifdef FETCH_ADDR_EXC_EN
            exc_d        = EXC_NONE;
            if (fetch_fault) begin
                ifid_d.instr = INSTR_NOP;
                exc_d        = EXC_ADEL;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= PC_RESET;
            ifid_q.instr <= INSTR_NOP;
            ifid_q.pc    <= PC_RESET;
            ifid_q.valid <= 1'b0;
`ifdef FETCH_ADDR_EXC_EN
            exc_q        <= EXC_NONE;
`endif
        end else begin
            // NOTE: registers are updated with non-blocking assignments so
            // every flop samples the pre-edge values regardless of order.
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
`ifdef FETCH_ADDR_EXC_EN
            exc_q  <= exc_d;
`endif
        end
    end

    // Word offset from the memory base, truncated to the memory depth.
    assign im_addr  = AW'((pc_q - PC_RESET) >> 2);
    assign if_pc    = pc_q;
    assign id_instr = ifid_q.instr;
    assign id_pc    = ifid_q.pc;
    assign id_pc8   = ifid_q.pc + (WORD_BYTES << 1);
    assign id_valid = ifid_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit : directed self-checking bench for fetch_unit.
// Expected values are queued while stimulus is set up and compared after the
// following clock edge (or immediately, for asynchronous reset).
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    typedef enum int {S_PC, S_IMA, S_INSTR, S_IDPC, S_PC8, S_VALID, S_EXC} sig_e;

    typedef struct {
        string       tag;
        sig_e        sig;
        logic [31:0] exp;
    } exp_t;

    localparam logic [31:0] ADDIU = 32'h2408_0001;
    localparam logic [31:0] SLOT  = 32'h2409_0002;
    localparam logic [31:0] BEQ   = 32'h1000_FFFE;
    localparam logic [31:0] JAL   = 32'h0C00_0C10;
    localparam logic [31:0] JR    = 32'h03E0_0008;
    localparam logic [31:0] OTHER = 32'h240A_0003;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [31:0] jr_target;
    logic [11:0] im_addr;
    logic [31:0] im_data;
    logic [31:0] if_pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc8;
    logic        id_valid;
`ifdef FETCH_ADDR_EXC_EN
    logic [4:0]  id_exc;
`endif

    logic [31:0] imem [0:4095];
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    assign im_data = imem[im_addr];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .npc_sel   (npc_sel),
        .br_taken  (br_taken),
        .jr_target (jr_target),
        .im_addr   (im_addr),
        .im_data   (im_data),
        .if_pc     (if_pc),
        .id_instr  (id_instr),
        .id_pc     (id_pc),
        .id_pc8    (id_pc8),
        .id_valid  (id_valid)
`ifdef FETCH_ADDR_EXC_EN
        ,
        .id_exc    (id_exc)
`endif
    );

    function automatic logic [31:0] sample(input sig_e s);
        case (s)
            S_PC:    return if_pc;
            S_IMA:   return {20'd0, im_addr};
            S_INSTR: return id_instr;
            S_IDPC:  return id_pc;
            S_PC8:   return id_pc8;
            S_VALID: return {31'd0, id_valid};
`ifdef FETCH_ADDR_EXC_EN
            S_EXC:   return {27'd0, id_exc};
`endif
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_v(input string tag, input sig_e s, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = s;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = sample(e.sig);
            checks++;
            assert (obs === e.exp)
            else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic expect_reset_state(input string tag);
        expect_v({tag, "_pc"},    S_PC,    32'h0000_3000);
        expect_v({tag, "_ima"},   S_IMA,   32'd0);
        expect_v({tag, "_instr"}, S_INSTR, 32'd0);
        expect_v({tag, "_idpc"},  S_IDPC,  32'h0000_3000);
        expect_v({tag, "_pc8"},   S_PC8,   32'h0000_3008);
        expect_v({tag, "_valid"}, S_VALID, 32'd0);
`ifdef FETCH_ADDR_EXC_EN
        expect_v({tag, "_exc"},   S_EXC,   32'd0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) imem[i] = ADDIU;
        imem[12'h002] = BEQ;
        imem[12'h003] = SLOT;
        imem[12'h004] = JAL;
        imem[12'h010] = JR;
        imem[12'h040] = OTHER;

        reset     = 1'b1;
        stall     = 1'b0;
        flush     = 1'b0;
        npc_sel   = 2'b00;
        br_taken  = 1'b0;
        jr_target = 32'd0;

        // Reset state
        #1;
        expect_reset_state("rst");
        check_all();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        expect_v("rel_pc",    S_PC,    32'h0000_3000);
        expect_v("rel_valid", S_VALID, 32'd0);
        check_all();

        // Sequential fetch
        expect_v("e1_ima",   S_IMA,   32'd1);
        expect_v("e1_idpc",  S_IDPC,  32'h0000_3000);
        expect_v("e1_valid", S_VALID, 32'd1);
        expect_v("e1_instr", S_INSTR, ADDIU);
        expect_v("e1_pc",    S_PC,    32'h0000_3004);
        tick();
        expect_v("e2_ima",   S_IMA,   32'd2);
        expect_v("e2_idpc",  S_IDPC,  32'h0000_3004);
        tick();
        expect_v("e3_idpc",  S_IDPC,  32'h0000_3008);
        expect_v("e3_instr", S_INSTR, BEQ);
        expect_v("e3_pc",    S_PC,    32'h0000_300C);
        tick();

        // Taken backward branch; delay slot still reaches ID
        npc_sel  = 2'b01;
        br_taken = 1'b1;
        expect_v("br_pc",     S_PC,    32'h0000_3004);
        expect_v("br_slotpc", S_IDPC,  32'h0000_300C);
        expect_v("br_slot",   S_INSTR, SLOT);
        expect_v("br_valid",  S_VALID, 32'd1);
        tick();
        npc_sel  = 2'b00;
        br_taken = 1'b0;
        expect_v("e5_pc", S_PC, 32'h0000_3008);
        tick();
        tick();
        expect_v("e7_pc", S_PC, 32'h0000_3010);
        tick();

        // jal in ID
        expect_v("jal_idpc",  S_IDPC,  32'h0000_3010);
        expect_v("jal_instr", S_INSTR, JAL);
        expect_v("jal_pc8",   S_PC8,   32'h0000_3018);
        tick();
        npc_sel = 2'b10;
        expect_v("jal_tgt",  S_PC,   32'h0000_3040);
        expect_v("jal_ima",  S_IMA,  32'h0000_0010);
        expect_v("jal_slot", S_IDPC, 32'h0000_3014);
        tick();
        npc_sel = 2'b00;
        expect_v("jr_idpc",  S_IDPC,  32'h0000_3040);
        expect_v("jr_instr", S_INSTR, JR);
        expect_v("jr_pc",    S_PC,    32'h0000_3044);
        tick();

        // jr held under a 2-cycle stall
        npc_sel   = 2'b11;
        jr_target = 32'h0000_3100;
        stall     = 1'b1;
        for (int c = 0; c < 2; c++) begin
            expect_v("stl_pc",    S_PC,    32'h0000_3044);
            expect_v("stl_idpc",  S_IDPC,  32'h0000_3040);
            expect_v("stl_instr", S_INSTR, JR);
            expect_v("stl_valid", S_VALID, 32'd1);
            tick();
        end
        stall = 1'b0;
        expect_v("jr_tgt",   S_PC,    32'h0000_3100);
        expect_v("jr_slot",  S_IDPC,  32'h0000_3044);
        expect_v("jr_valid", S_VALID, 32'd1);
        tick();

        // stall + flush together
        npc_sel = 2'b00;
        stall   = 1'b1;
        flush   = 1'b1;
        expect_v("sf_pc",    S_PC,    32'h0000_3100);
        expect_v("sf_valid", S_VALID, 32'd0);
        expect_v("sf_instr", S_INSTR, 32'd0);
        expect_v("sf_idpc",  S_IDPC,  32'h0000_3044);
        expect_v("sf_pc8",   S_PC8,   32'h0000_304C);
        tick();
        stall = 1'b0;
        flush = 1'b0;
        expect_v("sf_next_pc",    S_PC,    32'h0000_3104);
        expect_v("sf_next_idpc",  S_IDPC,  32'h0000_3100);
        expect_v("sf_next_instr", S_INSTR, OTHER);
        expect_v("sf_next_valid", S_VALID, 32'd1);
        tick();

        // flush alone: PC advances, ID becomes a bubble
        flush = 1'b1;
        expect_v("fl_pc",    S_PC,    32'h0000_3108);
        expect_v("fl_valid", S_VALID, 32'd0);
        expect_v("fl_idpc",  S_IDPC,  32'h0000_3100);
        tick();
        flush = 1'b0;
        expect_v("fl_next_idpc", S_IDPC, 32'h0000_3108);
        tick();

        // PC wrap at the top of the address space
        npc_sel   = 2'b11;
        jr_target = 32'hFFFF_FFFC;
        expect_v("top_pc",  S_PC,  32'hFFFF_FFFC);
        expect_v("top_ima", S_IMA, 32'h0000_03FF);
        tick();
        npc_sel = 2'b00;
        expect_v("wrap_pc",    S_PC,    32'h0000_0000);
        expect_v("wrap_ima",   S_IMA,   32'h0000_0400);
        expect_v("wrap_idpc",  S_IDPC,  32'hFFFF_FFFC);
        expect_v("wrap_pc8",   S_PC8,   32'h0000_0004);
        expect_v("wrap_valid", S_VALID, 32'd1);
`ifdef FETCH_ADDR_EXC_EN
        expect_v("wrap_exc",   S_EXC,   32'd4);
        expect_v("wrap_instr", S_INSTR, 32'd0);
`else
        expect_v("wrap_instr", S_INSTR, ADDIU);
`endif
        tick();

        // Asynchronous reset mid-cycle
        #2;
        reset = 1'b1;
        #1;
        expect_reset_state("mid_rst");
        check_all();
        reset = 1'b0;
        expect_v("post_rst_idpc",  S_IDPC,  32'h0000_3000);
        expect_v("post_rst_instr", S_INSTR, ADDIU);
        expect_v("post_rst_valid", S_VALID, 32'd1);
        expect_v("post_rst_pc",    S_PC,    32'h0000_3004);
        tick();

`ifdef FETCH_ADDR_EXC_EN
        // Misaligned and out-of-range fetches
        npc_sel   = 2'b11;
        jr_target = 32'h0000_3002;
        expect_v("mis_pc",  S_PC,  32'h0000_3002);
        expect_v("mis_pre", S_EXC, 32'd0);
        tick();
        npc_sel = 2'b00;
        expect_v("mis_exc",   S_EXC,   32'd4);
        expect_v("mis_instr", S_INSTR, 32'd0);
        expect_v("mis_idpc",  S_IDPC,  32'h0000_3002);
        expect_v("mis_valid", S_VALID, 32'd1);
        tick();
        npc_sel   = 2'b11;
        jr_target = 32'h0000_7000;
        expect_v("oor_pc", S_PC, 32'h0000_7000);
        tick();
        npc_sel = 2'b00;
        expect_v("oor_exc",   S_EXC,   32'd4);
        expect_v("oor_instr", S_INSTR, 32'd0);
        expect_v("oor_idpc",  S_IDPC,  32'h0000_7000);
        tick();
        flush = 1'b1;
        expect_v("oor_flush_exc", S_EXC, 32'd0);
        tick();
        flush = 1'b0;
`endif

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the five-stage MIPS pipeline.
- Holds the PC and drives the word address into the instruction memory.
- Captures the returned instruction into the IF/ID pipeline register.
- Computes the next PC from the instruction held in ID: sequential, branch, j/jal, or jr. Branches use delay-slot semantics, so nothing is squashed on a taken branch.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset; base address of instruction memory.
- IM_WORDS, 4096, instruction memory depth in words; im_addr is log2(IM_WORDS) bits wide.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard stall from hazard unit; freezes PC and IF/ID.
- flush  in  1  clear IF/ID to a bubble (exception/eret path).
- npc_sel  in  2  from ID controller: 00 PC+4, 01 branch, 10 j/jal, 11 jr.
- br_taken  in  1  branch comparison result from ID; used only when npc_sel=01.
- jr_target  in  32  forwarded rs value for jr/jalr.
- im_addr  out  12  word address to instruction memory = (pc - PC_RESET)[13:2].
- im_data  in  32  instruction word from memory, combinational on im_addr.
- if_pc  out  32  current fetch PC.
- id_instr  out  32  instruction in ID.
- id_pc  out  32  PC of instruction in ID.
- id_pc8  out  32  id_pc + 8, link value for jal/jalr.
- id_valid  out  1  ID holds a real instruction (0 = bubble).

Behaviour:
Reset (asynchronous, applied immediately):
- pc = PC_RESET; id_instr = 0; id_pc = PC_RESET; id_valid = 0.
- im_addr = 0 and id_pc8 = PC_RESET+8 as derived values.

Fetch:
- Fetch is combinational in the same cycle: im_addr is derived from pc, and im_data is sampled at the end of the cycle.
- Fetch-to-ID latency is 1 cycle.

Next-PC selection, evaluated from the ID contents:
- seq = pc + 4, 32-bit modulo; 0xFFFF_FFFC wraps to 0.
- br = id_pc + 4 + (sign_ext(id_instr[15:0]) << 2), used when npc_sel=01 and br_taken=1; otherwise seq.
- jmp = {id_pc[31:28] + 0... , id_instr[25:0], 2'b00}, i.e. id_pc+4 upper nibble concatenated with the index field.
- jr = jr_target as given; no alignment fix-up.
- If id_valid=0, npc_sel is ignored and seq is used.

Per rising edge, reset deasserted:
- stall=1, flush=0: pc holds; IF/ID holds. The held ID instruction re-evaluates its redirect on the first unstalled cycle.
- stall=1, flush=1: pc holds; IF/ID loads a bubble (id_instr=0, id_valid=0, id_pc unchanged).
- stall=0, flush=1: pc ← next PC; IF/ID loads a bubble.
- stall=0, flush=0: pc ← next PC; id_instr ← im_data, id_pc ← pc, id_valid ← 1.

Address bounds:
- im_addr is taken modulo IM_WORDS. No range check unless the optional feature is enabled.

Reset mid-operation:
- All state returns to reset values immediately.
- The first fetch after release is PC_RESET.

Optional Feature:
Macro FETCH_ADDR_EXC_EN.
- Enabled:
  - Adds output id_exc (5 bits), registered alongside IF/ID; reset value 0.
  - At fetch, the PC is faulting if pc[1:0]≠0 or pc is outside [PC_RESET, PC_RESET+4*IM_WORDS-1].
  - On a fault: IF/ID captures id_instr=0 with id_exc=4 (AdEL), id_valid=1, id_pc=faulting pc.
  - Otherwise id_exc=0; a bubble clears id_exc.
  - Behaviour while stalled or flushed is the same as for the other IF/ID fields.
- Disabled: port absent, no checking; behaviour as above.

Decomposition:
- Shared package mips_defs:
  - NPC_SEL encodings (NPC_PC4, NPC_BR, NPC_J, NPC_JR).
  - PC_RESET default.
  - EXC_ADEL = 5'd4.
  - Word/half constants.
- One natural sub-module, npc_calc: purely combinational next-PC mux and target adders. Leaves fetch_unit with the PC register, IF/ID register and control.

Test Plan:
1. Reset, then 3 clocks, im_data returns 0x2408_0001 (addiu) → im_addr 0,1,2; id_pc 0x3000 then 0x3004; id_valid rises 1 cycle after reset release.
2. beq in ID at id_pc 0x3008 with imm16=0xFFFE, npc_sel=01, br_taken=1 → next pc = 0x3004. Delay slot at 0x300C still reaches ID with id_valid=1.
3. jal in ID at 0x3010 with index 0x0000C10 → pc becomes 0x0000_3040; id_pc8 = 0x3018 while jal is in ID.
4. stall held 2 cycles with jr in ID, jr_target=0x3100 → pc and id_* frozen for 2 cycles; pc = 0x3100 one edge after stall drops.
5. stall=1 and flush=1 together → pc unchanged, id_valid=0, id_instr=0; next unstalled edge fetches the held pc.
6. FETCH_ADDR_EXC_EN defined, jr_target=0x3002 → next edge id_exc=4, id_instr=0, id_pc=0x3002. Repeat with 0x7000 → id_exc=4.
